// File: rtl/board_pattern_gen_if.sv
// Board pattern generator bus.
// Groups the start request and the generated board/status signals.
//   start       requester -> generator  request a new pattern (taken in IDLE only)
//   num_lit     requester -> generator  tiles to light, clamped to NUM_TILES
//   board       generator -> requester  bit i set = tile i lit
//   board_valid generator -> requester  board holds a complete pattern
//   busy        generator -> requester  generation in progress
//   done        generator -> requester  one-cycle completion pulse
interface board_pattern_gen_if #(
    parameter int unsigned NUM_TILES = 16,
    parameter int unsigned IDX_W     = 4
);
    logic                 start;
    logic [IDX_W:0]       num_lit;
    logic [NUM_TILES-1:0] board;
    logic                 board_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output start, num_lit,
        input  board, board_valid, busy, done
    );

    modport slave (
        input  start, num_lit,
        output board, board_valid, busy, done
    );
endinterface

// File: rtl/board_pattern_gen.sv
// Memory Matrix board pattern generator.
// On an accepted start it clears the board and then lights exactly N tiles, one per cycle,
// using a free-running 16-bit LFSR as the tile index source. Collisions are resolved by a
// linear probe upward (wrapping) to the first unlit tile, so every pick lands a new tile.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    board_pattern_gen_if slave: start/num_lit in, board/board_valid/busy/done out
module board_pattern_gen #(
    parameter int unsigned NUM_TILES = 16,
    parameter int unsigned IDX_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic                clk,
    input logic                reset,
    board_pattern_gen_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StClear, StPick, StDone} state_e;

    localparam logic [IDX_W:0] MaxLit = (IDX_W + 1)'(NUM_TILES);

    state_e               state_q;
    logic [15:0]          lfsr_q;
    logic [15:0]          lfsr_d;
    logic [IDX_W:0]       remaining_q;
    logic [NUM_TILES-1:0] board_q;
    logic                 board_valid_q;
    logic                 busy_q;
    logic                 done_q;

    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     target;
    logic                 found;

    // Fibonacci LFSR, taps 16,14,13,11; a non-zero seed never reaches zero.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Fold the raw LFSR index into range, then probe upward for the first free tile.
    // A free tile always exists during PICK because remaining never exceeds free tiles.
    always_comb begin
        int unsigned raw;
        int unsigned base;
        raw    = int'(lfsr_q[IDX_W-1:0]);
        base   = (raw >= NUM_TILES) ? raw - NUM_TILES : raw;
        idx    = IDX_W'(base);
        target = '0;
        found  = 1'b0;
        for (int unsigned off = 0; off < NUM_TILES; off++) begin
            int unsigned      pos;
            logic [IDX_W-1:0] pos_w;
            pos = base + off;
            if (pos >= NUM_TILES) begin
                pos = pos - NUM_TILES;
            end
            pos_w = IDX_W'(pos);
            if (!found && !board_q[pos_w]) begin
                found  = 1'b1;
                target = pos_w;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            lfsr_q        <= LFSR_SEED;
            remaining_q   <= '0;
            board_q       <= '0;
            board_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Shifting in every state lets start timing contribute entropy.
            lfsr_q <= lfsr_d;
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        remaining_q   <= (bus.num_lit > MaxLit) ? MaxLit : bus.num_lit;
                        busy_q        <= 1'b1;
                        board_valid_q <= 1'b0;
                        state_q       <= StClear;
                    end
                end
                StClear: begin
                    board_q <= '0;
                    state_q <= (remaining_q == '0) ? StDone : StPick;
                end
                StPick: begin
                    board_q[target] <= 1'b1;
                    remaining_q     <= remaining_q - 1'b1;
                    if (remaining_q == (IDX_W + 1)'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    board_valid_q <= 1'b1;
                    state_q       <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.board       = board_q;
    assign bus.board_valid = board_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    // idx is kept as a named signal for debug visibility.
    logic unused_idx;
    assign unused_idx = ^idx;

endmodule

// File: tb/tb_board_pattern_gen.sv
// Directed bench for board_pattern_gen: two instances (seeds ACE1 and 0001) share stimulus.
module tb_board_pattern_gen;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    board_pattern_gen_if #(.NUM_TILES(16), .IDX_W(4)) bus_a ();
    board_pattern_gen_if #(.NUM_TILES(16), .IDX_W(4)) bus_b ();

    assign bus_b.start   = bus_a.start;
    assign bus_b.num_lit = bus_a.num_lit;

    board_pattern_gen #(.NUM_TILES(16), .IDX_W(4), .LFSR_SEED(16'hACE1)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    board_pattern_gen #(.NUM_TILES(16), .IDX_W(4), .LFSR_SEED(16'h0001)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference LFSRs tracking each DUT cycle by cycle.
    logic [15:0] m_a;
    logic [15:0] m_b;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_a <= 16'hACE1;
            m_b <= 16'h0001;
        end else begin
            m_a <= lfsr_step(m_a);
            m_b <= lfsr_step(m_b);
        end
    end

    // l is the LFSR value right after the accepting edge; pick j uses l stepped j+1 times.
    function automatic logic [15:0] model_board(input logic [15:0] l_in, input int n);
        logic [15:0] b;
        logic [15:0] l;
        int          idx;
        int          pos;
        bit          hit;
        b = '0;
        l = l_in;
        for (int j = 0; j < n; j++) begin
            l   = lfsr_step(l);
            idx = int'(l[3:0]);
            hit = 1'b0;
            for (int off = 0; off < 16; off++) begin
                pos = (idx + off) % 16;
                if (!hit && !b[pos]) begin
                    b[pos] = 1'b1;
                    hit    = 1'b1;
                end
            end
        end
        return b;
    endfunction

    task automatic run_check(input int n, input string tag);
        int          nc;
        int          cnt;
        bit          busy_drop;
        logic [15:0] ea;
        logic [15:0] eb;
        nc = (n > 16) ? 16 : n;
        @(negedge clk);
        bus_a.start   = 1'b1;
        bus_a.num_lit = 5'(n);
        @(posedge clk);
        #1;
        bus_a.start   = 1'b0;
        bus_a.num_lit = ~bus_a.num_lit;  // later changes must be ignored
        ea = model_board(m_a, nc);
        eb = model_board(m_b, nc);
        total++;
        if (bus_a.busy !== 1'b1 || bus_a.board_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: busy=%b valid=%b want busy=1 valid=0", tag,
                     bus_a.busy, bus_a.board_valid);
        end
        cnt       = 0;
        busy_drop = 1'b0;
        while (cnt < 80) begin
            @(posedge clk);
            #1;
            cnt++;
            if (bus_a.done === 1'b1) break;
            if (bus_a.busy !== 1'b1) busy_drop = 1'b1;
        end
        total++;
        if (cnt != nc + 2) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, cnt, nc + 2);
        end
        total++;
        if (busy_drop) begin
            bad++;
            $display("FAIL %s busy: dropped before done, want held", tag);
        end
        total++;
        if (bus_a.board !== ea) begin
            bad++;
            $display("FAIL %s board_a: got %h want %h", tag, bus_a.board, ea);
        end
        total++;
        if (bus_b.board !== eb) begin
            bad++;
            $display("FAIL %s board_b: got %h want %h", tag, bus_b.board, eb);
        end
        total++;
        if ($countones(bus_a.board) != nc) begin
            bad++;
            $display("FAIL %s popcount: got %0d want %0d", tag, $countones(bus_a.board), nc);
        end
        total++;
        if (bus_a.board_valid !== 1'b1 || bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done_flags: valid=%b busy=%b want valid=1 busy=0", tag,
                     bus_a.board_valid, bus_a.busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus_a.done !== 1'b0 || bus_a.board !== ea || bus_a.board_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s after_done: done=%b board=%h valid=%b want 0 %h 1", tag,
                     bus_a.done, bus_a.board, bus_a.board_valid, ea);
        end
    endtask

    task automatic test_reset();
        total++;
        if (bus_a.board !== 16'h0 || bus_a.board_valid !== 1'b0 || bus_a.busy !== 1'b0 ||
            bus_a.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: board=%h valid=%b busy=%b done=%b want all 0",
                     bus_a.board, bus_a.board_valid, bus_a.busy, bus_a.done);
        end
        total++;
        if (dut_a.lfsr_q !== 16'hACE1) begin
            bad++;
            $display("FAIL reset_lfsr_a: got %h want ace1", dut_a.lfsr_q);
        end
        total++;
        if (dut_b.lfsr_q !== 16'h0001) begin
            bad++;
            $display("FAIL reset_lfsr_b: got %h want 0001", dut_b.lfsr_q);
        end
    endtask

    task automatic test_basic();
        run_check(5, "basic5");
        run_check(1, "single");
    endtask

    task automatic test_zero();
        run_check(0, "zero");
        total++;
        if (bus_a.board !== 16'h0) begin
            bad++;
            $display("FAIL zero_board: got %h want 0000", bus_a.board);
        end
    endtask

    task automatic test_clamp();
        run_check(20, "clamp20");
        total++;
        if (bus_a.board !== 16'hFFFF) begin
            bad++;
            $display("FAIL clamp_board: got %h want ffff", bus_a.board);
        end
        run_check(16, "full16");
    endtask

    task automatic test_ignore_restart();
        logic [15:0] ea;
        int          ndone;
        int          done_at;
        @(negedge clk);
        bus_a.start   = 1'b1;
        bus_a.num_lit = 5'd6;
        @(posedge clk);
        #1;
        ea      = model_board(m_a, 6);
        ndone   = 0;
        done_at = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus_a.start = (c == 3 || c == 5);
            @(posedge clk);
            #1;
            if (bus_a.done === 1'b1) begin
                ndone++;
                done_at = c;
            end
        end
        total++;
        if (ndone != 1 || done_at != 8) begin
            bad++;
            $display("FAIL restart_done: pulses=%0d at=%0d want 1 at 8", ndone, done_at);
        end
        total++;
        if (bus_a.board !== ea || bus_a.busy !== 1'b0 || bus_a.board_valid !== 1'b1) begin
            bad++;
            $display("FAIL restart_board: board=%h busy=%b valid=%b want %h 0 1",
                     bus_a.board, bus_a.busy, bus_a.board_valid, ea);
        end
        run_check(4, "after_restart");
    endtask

    task automatic test_held_start();
        logic [15:0] ea;
        int          cnt;
        @(negedge clk);
        bus_a.start   = 1'b1;
        bus_a.num_lit = 5'd2;
        @(posedge clk);
        #1;
        ea = model_board(m_a, 2);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (bus_a.done !== 1'b1 || bus_a.board !== ea) begin
            bad++;
            $display("FAIL held_first: done=%b board=%h want 1 %h", bus_a.done, bus_a.board, ea);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus_a.busy !== 1'b1 || bus_a.board_valid !== 1'b0) begin
            bad++;
            $display("FAIL held_reaccept: busy=%b valid=%b want 1 0", bus_a.busy,
                     bus_a.board_valid);
        end
        ea = model_board(m_a, 2);
        bus_a.start = 1'b0;
        cnt = 0;
        while (cnt < 40 && bus_a.done !== 1'b1) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        total++;
        if (cnt != 4 || bus_a.board !== ea) begin
            bad++;
            $display("FAIL held_second: cycles=%0d board=%h want 4 %h", cnt, bus_a.board, ea);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus_a.start   = 1'b1;
        bus_a.num_lit = 5'd8;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus_a.board !== 16'h0 || bus_a.board_valid !== 1'b0 || bus_a.busy !== 1'b0 ||
            bus_a.done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: board=%h valid=%b busy=%b done=%b want all 0",
                     bus_a.board, bus_a.board_valid, bus_a.busy, bus_a.done);
        end
        total++;
        if (dut_a.lfsr_q !== 16'hACE1) begin
            bad++;
            $display("FAIL midreset_lfsr: got %h want ace1", dut_a.lfsr_q);
        end
        @(negedge clk);
        reset = 1'b1;
        run_check(3, "post_reset");
    endtask

    task automatic test_random();
        int n;
        int gap;
        for (int r = 0; r < 300; r++) begin
            n   = $urandom_range(0, 16);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(posedge clk);
            run_check(n, $sformatf("rand%0d_n%0d", r, n));
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        bus_a.start   = 1'b0;
        bus_a.num_lit = '0;
        #22;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_basic();
        test_zero();
        test_clamp();
        test_ignore_restart();
        test_held_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
